// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and defaults for the BRAM Port B read arbiter.
// Optional build macro: BRAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_BURST_LEN  = 32;

  // Width of a requester index; never below one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot pick among the request bits.
// Default: round-robin, search starts one past the last-served index (ptr).
// With BRAM_ARB_FIXED_PRIO_EN defined: lowest index wins and ptr does not exist.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int OW = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef BRAM_ARB_FIXED_PRIO_EN
  input  logic [OW-1:0]      ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [OW-1:0]      idx,
  output logic               any
);

  logic          w_found;
  logic [OW-1:0] w_cand;

  assign any = |req;

  // Scan candidates in priority order and keep the first requesting one.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = OW'((int'(ptr) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        idx         = w_cand;
        gnt[w_cand] = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = OW'(k);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        idx         = w_cand;
        gnt[w_cand] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares BRAM Port B among NUM_REQ tile fetchers.
// Each grant issues BURST_LEN consecutive reads, then drains RD_LATENCY
// cycles; returned data carries owner tag and last flag.
// Optional build macro: BRAM_ARB_FIXED_PRIO_EN (fixed priority, no rr pointer).
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int RD_LATENCY = 1,
  localparam int OW = owner_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [OW-1:0]                 rd_owner,
  output logic                          rd_last
);

  localparam int CW = $clog2(BURST_LEN);

  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cnt;
  logic [1:0]              r_dcnt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [OW-1:0]           r_owner;

  logic [NUM_REQ-1:0]      w_arb_gnt;
  logic [OW-1:0]           w_arb_idx;
  logic                    w_any;
  logic                    w_issue_last;
  logic [ADDR_WIDTH-1:0]   w_base_arr [NUM_REQ];

  logic [RD_LATENCY-1:0]           r_vld_sr;
  logic [RD_LATENCY-1:0]           r_last_sr;
  logic [RD_LATENCY-1:0][OW-1:0]   r_own_sr;

  // Split the flat base address bus into one slice per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_base
      assign w_base_arr[gi] = base_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic [OW-1:0] r_ptr;

  // Pointer follows the most recent winner so the next search starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= OW'(NUM_REQ - 1);
    else if (r_state == IDLE && w_any)
      r_ptr <= w_arb_idx;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_any)
  );
`else
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_any)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: arbitrate, issue BURST_LEN reads, wait out read latency.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = BURST;
      BURST:   if (r_cnt == CW'(BURST_LEN - 1)) w_state_next = DRAIN;
      DRAIN:   if (r_dcnt == 2'(RD_LATENCY - 1)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Port B drive: only active while issuing; address wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    bram_en      = 1'b0;
    bram_addr    = '0;
    w_issue_last = 1'b0;
    if (r_state == BURST) begin
      bram_en      = 1'b1;
      bram_addr    = r_base + ADDR_WIDTH'(r_cnt);
      w_issue_last = (r_cnt == CW'(BURST_LEN - 1));
    end
  end

  // Burst bookkeeping: latch winner on grant, count issues and drain cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_base  <= '0;
      r_gnt   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_base  <= w_base_arr[w_arb_idx];
            r_gnt   <= w_arb_gnt;
            r_owner <= w_arb_idx;
            r_cnt   <= '0;
          end
        end
        BURST: begin
          r_cnt  <= r_cnt + CW'(1);
          r_dcnt <= '0;
        end
        DRAIN: begin
          r_dcnt <= r_dcnt + 2'd1;
          if (w_state_next == IDLE) r_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Delay the issue strobe, owner and last flag to line up with returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
      r_own_sr  <= '0;
    end else begin
      r_vld_sr[0]  <= bram_en;
      r_last_sr[0] <= w_issue_last;
      r_own_sr[0]  <= bram_en ? r_owner : '0;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_vld_sr[k]  <= r_vld_sr[k-1];
        r_last_sr[k] <= r_last_sr[k-1];
        r_own_sr[k]  <= r_own_sr[k-1];
      end
    end
  end

  assign gnt      = r_gnt;
  assign rd_valid = r_vld_sr[RD_LATENCY-1];
  assign rd_last  = r_last_sr[RD_LATENCY-1];
  assign rd_owner = r_own_sr[RD_LATENCY-1];
  assign rd_data  = bram_dout;
  // Grant is still held during drain, so it names the owner of the last word.
  assign done     = rd_last ? r_gnt : '0;

endmodule
